capture_buffer_ram: RTL and testbench
=====================================

Name: capture_buffer_ram

Overview:
Parametrised circular sample buffer for the logic analyzer capture path. Stores sampled channel data in distributed/LUT RAM while armed, marks the trigger sample, then captures a programmable number of post-trigger samples before freezing. After the capture freezes, the host side reads the buffer out in chronological order through a registered read port.

Parameters:
DATA_W, 8, sample width (number of probed channels)
ADDR_W, 7, address width; depth DEPTH = 2**ADDR_W samples

Ports:
CLK  input  1  system clock; all logic on rising edge
RST_N  input  1  asynchronous active-low reset
DIN  input  DATA_W  sample data
SAMPLE_EN  input  1  sample strobe; one write per high cycle while capturing
ARM  input  1  start/restart capture (single-cycle pulse)
TRIG  input  1  trigger condition, qualified by SAMPLE_EN
POST_CNT  input  ADDR_W  samples to store after the trigger sample; latched on the trigger
RD_EN  input  1  read request; honoured only in DONE
RD_OFS  input  ADDR_W  read offset from the oldest stored sample
DOUT  output  DATA_W  read data, registered
DOUT_VALID  output  1  one-cycle pulse with each DOUT update
ARMED  output  1  high in PRE and POST
DONE  output  1  high in DONE
TRIG_ADDR  output  ADDR_W  physical address of the trigger sample
FILL_CNT  output  ADDR_W+1  valid samples stored; saturates at DEPTH

Behaviour:
- The RAM array is not reset. The memory is inferred as distributed RAM. There is one write port, plus a synchronous read into the DOUT register.
- RST_N low (asynchronous) sets: state IDLE; write pointer, post counter, TRIG_ADDR, FILL_CNT, DOUT and DOUT_VALID all 0.
- States: IDLE, PRE, POST, DONE.
- ARM in any state:
  - Next state PRE.
  - Write pointer, FILL_CNT and the wrapped flag are cleared.
  - Any SAMPLE_EN or TRIG in that same cycle is ignored, so ARM wins.
- PRE, on SAMPLE_EN:
  - Write DIN to RAM[wr_ptr].
  - wr_ptr increments modulo DEPTH.
  - FILL_CNT increments, saturating at DEPTH.
  - The wrapped flag sets when wr_ptr rolls from DEPTH-1 to 0.
- PRE, on SAMPLE_EN and TRIG together:
  - The sample is written as above.
  - TRIG_ADDR <= wr_ptr (pre-increment value).
  - Post counter <= POST_CNT.
  - Next state is DONE if POST_CNT = 0, otherwise POST.
- TRIG without SAMPLE_EN is ignored.
- POST, on SAMPLE_EN:
  - Write the sample as in PRE.
  - Post counter decrements.
  - When the counter reaches 0 on this write, the next state is DONE.
  - TRIG is ignored in POST.
- POST_CNT is at most DEPTH-1, so the trigger sample is never overwritten.
- DONE:
  - Writes are blocked and SAMPLE_EN is ignored. wr_ptr, FILL_CNT and TRIG_ADDR hold.
  - Oldest sample address: base = wrapped ? wr_ptr : 0.
  - RD_EN reads from physical address (base + RD_OFS) mod DEPTH.
  - DOUT updates on the next rising edge, with DOUT_VALID high for exactly that cycle. Read latency is 1 cycle.
  - Back-to-back RD_EN gives one result per cycle.
- RD_EN outside DONE is ignored: DOUT holds its value and DOUT_VALID stays 0.
- RD_OFS >= FILL_CNT while not wrapped returns stale RAM contents. This is not an error and no flag is raised.
- IDLE: all inputs except ARM are ignored.
- Reset asserted mid-capture: the capture is aborted immediately and the state is IDLE. Stored data stays in RAM but is not readable until a new capture completes.

Test Plan:
All scenarios use DATA_W=8, ADDR_W=4, DEPTH=16.
1. ARM; POST_CNT=2; samples 0x10..0x14 with TRIG on 0x12 -> DONE after 0x14; FILL_CNT=5; TRIG_ADDR=2; RD_OFS 0..4 return 0x10..0x14, each one cycle after RD_EN, with a DOUT_VALID pulse.
2. Wrap: ARM; POST_CNT=2; samples 0..19 with TRIG on sample 17 -> FILL_CNT=16; TRIG_ADDR=1; RD_OFS=0 returns 4; RD_OFS=15 returns 19; back-to-back reads of RD_OFS 0..15 stream 4..19 on consecutive cycles.
3. POST_CNT=0; TRIG on the first sample 0xA5 -> DONE the next cycle; FILL_CNT=1; TRIG_ADDR=0; RD_OFS=0 returns 0xA5. Further SAMPLE_EN with 0xFF changes nothing.
4. ARM and TRIG high together with SAMPLE_EN -> state PRE, FILL_CNT=0, no trigger. TRIG asserted without SAMPLE_EN -> no state change.
5. RST_N low for 1 cycle in POST after 3 post samples -> IDLE immediately; all outputs 0; RD_EN produces no DOUT_VALID. A re-ARMed capture then runs normally.
6. RD_EN in PRE -> DOUT unchanged, DOUT_VALID=0. ARM in DONE -> PRE with FILL_CNT=0.

Source files
------------

// File: rtl/capture_buffer_ram.sv
// capture_buffer_ram: circular sample buffer with trigger marking, post-trigger count and chronological readout
module capture_buffer_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              sample_en,
   input  logic              arm,
   input  logic              trig,
   input  logic [ADDR_W-1:0] post_cnt,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_ofs,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              armed,
   output logic              done,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [ADDR_W:0]   fill_cnt
);
   localparam int DEPTH = 1 << ADDR_W;
   typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;
   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic                wrapped_q, wrapped_d;
   logic [ADDR_W:0]     fill_q, fill_d;
   logic [ADDR_W-1:0]   post_q, post_d;
   logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic                we;
   logic [ADDR_W-1:0]   rd_addr;
   logic [DATA_W-1:0]   mem [DEPTH];
   // once wrapped, the oldest sample sits at the write pointer
   assign rd_addr = (wrapped_q ? wr_ptr_q : '0) + rd_ofs;
   // next-state logic: arm restarts, PRE/POST store samples, DONE serves reads
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      wrapped_d    = wrapped_q;
      fill_d       = fill_q;
      post_d       = post_q;
      trig_addr_d  = trig_addr_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      we           = 1'b0;
      if (arm) begin
         state_d   = PRE;
         wr_ptr_d  = '0;
         fill_d    = '0;
         wrapped_d = 1'b0;
      end else begin
         case (state_q)
            PRE, POST: begin
               if (sample_en) begin
                  we        = 1'b1;
                  wr_ptr_d  = wr_ptr_q + 1'b1;
                  fill_d    = (fill_q == (ADDR_W+1)'(DEPTH)) ? fill_q : fill_q + 1'b1;
                  wrapped_d = wrapped_q | (&wr_ptr_q);
                  if (state_q == PRE && trig) begin
                     trig_addr_d = wr_ptr_q;
                     post_d      = post_cnt;
                     state_d     = (post_cnt == '0) ? DONE : POST;
                  end else if (state_q == POST) begin
                     post_d  = post_q - 1'b1;
                     state_d = (post_q == ADDR_W'(1)) ? DONE : POST;
                  end
               end
            end
            DONE: begin
               if (rd_en) begin
                  dout_d       = mem[rd_addr];
                  dout_valid_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
   // control and read-port registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         wrapped_q    <= 1'b0;
         fill_q       <= '0;
         post_q       <= '0;
         trig_addr_q  <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         wrapped_q    <= wrapped_d;
         fill_q       <= fill_d;
         post_q       <= post_d;
         trig_addr_q  <= trig_addr_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end
   // sample storage, no reset so it maps onto distributed RAM
   always_ff @(posedge clk) begin
      if (we) mem[wr_ptr_q] <= din;
   end
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign armed      = (state_q == PRE) || (state_q == POST);
   assign done       = (state_q == DONE);
   assign trig_addr  = trig_addr_q;
   assign fill_cnt   = fill_q;
endmodule

// File: tb/tb_capture_buffer_ram.sv
// tb_capture_buffer_ram: directed vector bench for the capture buffer at DEPTH=16
module tb_capture_buffer_ram;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = '0;
   logic       sample_en = 1'b0;
   logic       arm = 1'b0;
   logic       trig = 1'b0;
   logic [3:0] post_cnt = '0;
   logic       rd_en = 1'b0;
   logic [3:0] rd_ofs = '0;
   logic [7:0] dout;
   logic       dout_valid;
   logic       armed;
   logic       done;
   logic [3:0] trig_addr;
   logic [4:0] fill_cnt;
   int         n_vec = 0;
   int         n_bad = 0;

   typedef struct {
      logic       a, s, t;
      logic [7:0] d;
      logic [3:0] pc;
      logic       r;
      logic [3:0] o;
      logic       e_armed, e_done;
      logic [4:0] e_fill;
      logic [3:0] e_ta;
      logic       e_dv;
      logic [7:0] e_dout;
      logic       chk_dout;
   } vec_t;
   vec_t tbl[12];

   capture_buffer_ram #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .sample_en(sample_en), .arm(arm),
      .trig(trig), .post_cnt(post_cnt), .rd_en(rd_en), .rd_ofs(rd_ofs),
      .dout(dout), .dout_valid(dout_valid), .armed(armed), .done(done),
      .trig_addr(trig_addr), .fill_cnt(fill_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic a, s, t, input logic [7:0] d, input logic [3:0] pc,
                               input logic r, input logic [3:0] o, input logic ea, ed,
                               input logic [4:0] ef, input logic [3:0] eta, input logic edv,
                               input logic [7:0] edo, input logic cd);
      vec_t v;
      v.a = a; v.s = s; v.t = t; v.d = d; v.pc = pc; v.r = r; v.o = o;
      v.e_armed = ea; v.e_done = ed; v.e_fill = ef; v.e_ta = eta;
      v.e_dv = edv; v.e_dout = edo; v.chk_dout = cd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic a, s, t, input logic [7:0] d, input logic [3:0] pc,
                       input logic r, input logic [3:0] o);
      arm = a; sample_en = s; trig = t; din = d; post_cnt = pc; rd_en = r; rd_ofs = o;
      @(posedge clk);
      #1;
      arm = 1'b0; sample_en = 1'b0; trig = 1'b0; rd_en = 1'b0;
   endtask

   task automatic chk_st(input string nm, input logic ea, ed, input logic [4:0] ef);
      chk({nm, ".armed"}, 32'(armed), 32'(ea));
      chk({nm, ".done"}, 32'(done), 32'(ed));
      chk({nm, ".fill"}, 32'(fill_cnt), 32'(ef));
   endtask

   initial begin
      tbl[0]  = mk(1,0,0,8'h00,0,0,0, 1,0,5'd0,4'd0,0,8'h00,1);
      tbl[1]  = mk(0,1,0,8'h10,0,0,0, 1,0,5'd1,4'd0,0,8'h00,1);
      tbl[2]  = mk(0,1,0,8'h11,0,0,0, 1,0,5'd2,4'd0,0,8'h00,1);
      tbl[3]  = mk(0,1,1,8'h12,2,0,0, 1,0,5'd3,4'd2,0,8'h00,1);
      tbl[4]  = mk(0,1,0,8'h13,2,0,0, 1,0,5'd4,4'd2,0,8'h00,1);
      tbl[5]  = mk(0,1,0,8'h14,2,0,0, 0,1,5'd5,4'd2,0,8'h00,1);
      tbl[6]  = mk(0,0,0,8'h00,2,1,0, 0,1,5'd5,4'd2,1,8'h10,1);
      tbl[7]  = mk(0,0,0,8'h00,2,1,1, 0,1,5'd5,4'd2,1,8'h11,1);
      tbl[8]  = mk(0,0,0,8'h00,2,1,2, 0,1,5'd5,4'd2,1,8'h12,1);
      tbl[9]  = mk(0,0,0,8'h00,2,1,3, 0,1,5'd5,4'd2,1,8'h13,1);
      tbl[10] = mk(0,0,0,8'h00,2,1,4, 0,1,5'd5,4'd2,1,8'h14,1);
      tbl[11] = mk(0,0,0,8'h00,2,0,0, 0,1,5'd5,4'd2,0,8'h14,1);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_st("reset", 0, 0, 5'd0);
      chk("reset.trig_addr", 32'(trig_addr), 0);
      chk("reset.dout", 32'(dout), 0);
      chk("reset.dv", 32'(dout_valid), 0);
      rst_n = 1'b1;

      // scenario 1: basic capture and readout
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].a, tbl[i].s, tbl[i].t, tbl[i].d, tbl[i].pc, tbl[i].r, tbl[i].o);
         chk_st($sformatf("v%0d", i), tbl[i].e_armed, tbl[i].e_done, tbl[i].e_fill);
         chk($sformatf("v%0d.trig_addr", i), 32'(trig_addr), 32'(tbl[i].e_ta));
         chk($sformatf("v%0d.dv", i), 32'(dout_valid), 32'(tbl[i].e_dv));
         if (tbl[i].chk_dout) chk($sformatf("v%0d.dout", i), 32'(dout), 32'(tbl[i].e_dout));
      end

      // scenario 2: wrap-around, trigger on sample 17
      step(1,0,0,0,2,0,0);
      for (int i = 0; i < 20; i++) begin
         step(0,1,(i == 17),8'(i),2,0,0);
         if (i == 18) chk_st("wrap.s18", 1, 0, 5'd16);
      end
      chk_st("wrap.end", 0, 1, 5'd16);
      chk("wrap.trig_addr", 32'(trig_addr), 1);
      step(0,0,0,0,2,1,4'd15);
      chk("wrap.ofs15", 32'(dout), 19);
      for (int i = 0; i < 16; i++) begin
         step(0,0,0,0,2,1,4'(i));
         chk($sformatf("wrap.b2b%0d.dv", i), 32'(dout_valid), 1);
         chk($sformatf("wrap.b2b%0d.dout", i), 32'(dout), 32'(4 + i));
      end

      // scenario 3: zero post count, trigger on first sample
      step(1,0,0,0,0,0,0);
      step(0,1,1,8'hA5,0,0,0);
      chk_st("pc0", 0, 1, 5'd1);
      chk("pc0.trig_addr", 32'(trig_addr), 0);
      step(0,1,0,8'hFF,0,0,0);
      step(0,1,1,8'hFF,0,0,0);
      chk_st("pc0.hold", 0, 1, 5'd1);
      step(0,0,0,0,0,1,0);
      chk("pc0.dout", 32'(dout), 32'hA5);
      chk("pc0.dv", 32'(dout_valid), 1);

      // scenario 4: arm beats same-cycle trigger; trig without sample ignored
      step(1,1,1,8'h55,0,0,0);
      chk_st("armwin", 1, 0, 5'd0);
      step(0,0,1,8'h00,0,0,0);
      chk_st("trig_nose", 1, 0, 5'd0);
      step(0,1,0,8'h66,0,0,0);
      chk_st("pre_sample", 1, 0, 5'd1);

      // scenario 5: asynchronous reset during POST
      step(0,1,0,8'h01,0,0,0);
      step(0,1,1,8'h02,5,0,0);
      chk("rst.trig_addr_pre", 32'(trig_addr), 2);
      for (int i = 0; i < 3; i++) step(0,1,0,8'(8'h20 + i),5,0,0);
      chk_st("rst.post", 1, 0, 5'd6);
      rst_n = 1'b0;
      #2;
      chk_st("rst.async", 0, 0, 5'd0);
      chk("rst.trig_addr", 32'(trig_addr), 0);
      chk("rst.dout", 32'(dout), 0);
      chk("rst.dv", 32'(dout_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(0,0,0,0,0,1,0);
      chk("rst.rd_dv", 32'(dout_valid), 0);
      chk_st("rst.idle", 0, 0, 5'd0);
      step(0,1,1,8'h77,0,0,0);
      chk_st("idle.ignore", 0, 0, 5'd0);
      step(1,0,0,0,0,0,0);
      step(0,1,0,8'h30,1,0,0);
      step(0,1,1,8'h31,1,0,0);
      step(0,1,0,8'h32,1,0,0);
      chk_st("rearm", 0, 1, 5'd3);
      chk("rearm.trig_addr", 32'(trig_addr), 1);
      step(0,0,0,0,1,1,4'd2);
      chk("rearm.dout", 32'(dout), 32'h32);

      // scenario 6: arm from DONE, then read attempt in PRE
      step(1,0,0,0,0,0,0);
      chk_st("done_arm", 1, 0, 5'd0);
      step(0,0,0,0,0,1,0);
      chk("pre_rd.dv", 32'(dout_valid), 0);
      chk("pre_rd.dout", 32'(dout), 32'h32);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
